// File: rtl/clock_time_ctrl.sv
// Timekeeping and time-set controller: hour/minute/second counters advanced
// by a 1 Hz enable, plus a button-driven set mode that edits one field at a
// time, with blink strobe and an idle timeout back to run.
module clock_time_ctrl #(
  parameter int WIDTH_HR    = 5,
  parameter int WIDTH_MIN   = 6,
  parameter int WIDTH_SEC   = 6,
  parameter int SET_TIMEOUT = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_1hz,
  input  logic                 set_btn,
  input  logic                 inc_btn,
  input  logic                 dec_btn,
  output logic [WIDTH_HR-1:0]  cntHr,
  output logic [WIDTH_MIN-1:0] cntMin,
  output logic [WIDTH_SEC-1:0] cntSec,
  output logic [1:0]           field_sel,
  output logic                 blink,
  output logic                 setting
);

  localparam int IDLE_W = $clog2(SET_TIMEOUT + 1);

  localparam logic [WIDTH_HR-1:0]  HR_MAX  = WIDTH_HR'(23);
  localparam logic [WIDTH_MIN-1:0] MIN_MAX = WIDTH_MIN'(59);
  localparam logic [WIDTH_SEC-1:0] SEC_MAX = WIDTH_SEC'(59);
  localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(SET_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [WIDTH_HR-1:0]  hr_nx;
  logic [WIDTH_MIN-1:0] min_nx;
  logic [WIDTH_SEC-1:0] sec_nx;
  logic [IDLE_W-1:0]    idle, idle_nx;
  logic                 blink_nx;
  logic                 edit_inc, edit_dec, edit_press;

  // Simultaneous inc and dec cancel each other but still count as a press.
  assign edit_inc   = inc_btn & ~dec_btn;
  assign edit_dec   = dec_btn & ~inc_btn;
  assign edit_press = inc_btn | dec_btn;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  // Next state, next time values, blink and idle counter
  always_comb begin
    state_nx = state;
    hr_nx    = cntHr;
    min_nx   = cntMin;
    sec_nx   = cntSec;
    blink_nx = blink;
    idle_nx  = idle;

    unique case (state)
      RUN: begin
        blink_nx = 1'b0;
        idle_nx  = '0;
        if (tick_1hz) begin
          // Out-of-range values are treated as the wrap point.
          if (cntSec >= SEC_MAX) begin
            sec_nx = '0;
            if (cntMin >= MIN_MAX) begin
              min_nx = '0;
              hr_nx  = (cntHr >= HR_MAX) ? '0 : cntHr + 1'b1;
            end else begin
              min_nx = cntMin + 1'b1;
            end
          end else begin
            sec_nx = cntSec + 1'b1;
          end
        end
        if (set_btn) state_nx = SET_HR;
      end

      default: begin
        if (set_btn) begin
          // Field advance wins over any inc/dec in the same cycle.
          idle_nx = '0;
          unique case (state)
            SET_HR:  state_nx = SET_MIN;
            SET_MIN: state_nx = SET_SEC;
            default: state_nx = RUN;
          endcase
          if (state_nx == RUN) blink_nx = 1'b0;
          else if (tick_1hz)   blink_nx = ~blink;
        end else if (edit_press) begin
          idle_nx  = '0;
          blink_nx = 1'b0;
          unique case (state)
            SET_HR: begin
              if (edit_inc) hr_nx = (cntHr >= HR_MAX) ? '0 : cntHr + 1'b1;
              if (edit_dec) hr_nx = (cntHr == '0 || cntHr > HR_MAX) ? HR_MAX : cntHr - 1'b1;
            end
            SET_MIN: begin
              if (edit_inc) min_nx = (cntMin >= MIN_MAX) ? '0 : cntMin + 1'b1;
              if (edit_dec) min_nx = (cntMin == '0 || cntMin > MIN_MAX) ? MIN_MAX : cntMin - 1'b1;
            end
            default: begin
              if (edit_inc) sec_nx = (cntSec >= SEC_MAX) ? '0 : cntSec + 1'b1;
              if (edit_dec) sec_nx = (cntSec == '0 || cntSec > SEC_MAX) ? SEC_MAX : cntSec - 1'b1;
            end
          endcase
        end else if (tick_1hz) begin
          if (idle >= IDLE_LAST) begin
            state_nx = RUN;
            idle_nx  = '0;
            blink_nx = 1'b0;
          end else begin
            idle_nx  = idle + 1'b1;
            blink_nx = ~blink;
          end
        end
      end
    endcase
  end

  // Registered time counters, blink strobe, idle counter and state decode
  always_ff @(posedge clk) begin
    if (rst) begin
      cntHr     <= '0;
      cntMin    <= '0;
      cntSec    <= '0;
      blink     <= 1'b0;
      idle      <= '0;
      field_sel <= 2'd0;
      setting   <= 1'b0;
    end else begin
      cntHr     <= hr_nx;
      cntMin    <= min_nx;
      cntSec    <= sec_nx;
      blink     <= blink_nx;
      idle      <= idle_nx;
      field_sel <= state_nx;
      setting   <= (state_nx != RUN);
    end
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Timekeeping and time-set controller for the configurable digital clock.
- Holds the hour, minute and second counters and advances them on a 1 Hz enable.
- Sequences a set mode, driven by set/inc/dec button pulses, in which the user edits one field at a time.
- Its count outputs feed the BCD converter and display stages downstream; 12/24 h formatting is not done here.

Parameters:
- WIDTH_HR, 5, width of the hour count output (hours 0..23)
- WIDTH_MIN, 6, width of the minute count output (minutes 0..59)
- WIDTH_SEC, 6, width of the second count output (seconds 0..59)
- SET_TIMEOUT, 30, number of idle tick_1hz pulses in set mode before an automatic return to run

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- tick_1hz  input  1  one-cycle enable, once per second
- set_btn  input  1  one-cycle debounced pulse: enter set mode / advance field
- inc_btn  input  1  one-cycle debounced pulse: increment selected field
- dec_btn  input  1  one-cycle debounced pulse: decrement selected field
- cntHr  output  WIDTH_HR  hours, 0..23
- cntMin  output  WIDTH_MIN  minutes, 0..59
- cntSec  output  WIDTH_SEC  seconds, 0..59
- field_sel  output  2  field being edited: 0 none, 1 hr, 2 min, 3 sec
- blink  output  1  display blank strobe for the selected field
- setting  output  1  high in any set state

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- All outputs are registered. Every action below takes effect on the clk edge where its input is sampled high; latency is 1 cycle.
- Reset values: cntHr=0, cntMin=0, cntSec=0, field_sel=0, blink=0, setting=0, state=RUN, idle counter=0.
- A reset mid-edit discards any pending edit state and returns to RUN with zeroed time.
- States are RUN, SET_HR, SET_MIN, SET_SEC.
- Transitions: RUN -set_btn-> SET_HR -set_btn-> SET_MIN -set_btn-> SET_SEC -set_btn-> RUN.
- field_sel and setting follow the state: RUN=0/0, SET_HR=1/1, SET_MIN=2/1, SET_SEC=3/1.
- RUN, on tick_1hz:
  - cntSec increments.
  - 59->0 wraps cntSec and increments cntMin in the same edge.
  - cntMin 59->0 likewise increments cntHr.
  - cntHr 23->0 wraps.
  - At 23:59:59 a single tick yields 00:00:00.
- RUN ignores inc_btn and dec_btn.
- RUN with set_btn and tick_1hz in the same cycle: the time advances AND the state goes to SET_HR.
- Set states:
  - tick_1hz does not advance the time.
  - inc_btn adds 1 to the selected field modulo its range: hr 23->0, min/sec 59->0.
  - dec_btn subtracts 1 with wrap: hr 0->23, min/sec 0->59.
  - There is no carry between fields.
- Set-state priority:
  - set_btn beats inc/dec in the same cycle: the field advances and the inc/dec is dropped.
  - inc_btn and dec_btn together with no set_btn: no change.
- blink:
  - Toggles on each tick_1hz while setting=1.
  - Forced to 0 on the edge entering RUN or SET_HR.
  - Forced to 0 on any inc/dec press, so an edited value shows immediately.
- Idle timeout:
  - The idle counter (width ceil(log2(SET_TIMEOUT+1))) clears on state entry and on any set/inc/dec pulse.
  - It increments on tick_1hz in set states.
  - When it reaches SET_TIMEOUT, the state goes to RUN on that edge. Edited values are retained; field_sel=0, setting=0, blink=0.
  - A tick in the same cycle as a button press clears the counter; the button wins.
- Leaving SET_SEC (button or timeout): the first tick_1hz after return to RUN counts normally.
- Count outputs never hold out-of-range values. Out-of-range values are unreachable, but if forced they wrap to 0 on the next increment.

Test Plan:
- Reset, then 3661 tick_1hz pulses -> cntHr=1, cntMin=1, cntSec=1; field_sel=0, setting=0.
- Preload 23:59:59 through the set sequence, return to RUN, apply 1 tick -> 00:00:00 on that edge, no intermediate values.
- set_btn; dec_btn ×1 -> cntHr=23, field_sel=1, blink=0; set_btn; inc_btn ×60 -> cntMin unchanged (wrap), cntHr still 23; set_btn ×2 -> field_sel=0, setting=0.
- In SET_MIN, send set_btn+inc_btn in the same cycle -> field_sel=3, cntMin unchanged; then inc_btn+dec_btn together -> cntSec unchanged.
- Enter SET_HR, 29 ticks -> still SET_HR with blink toggling each tick; inc_btn; 29 ticks -> still SET_HR; 1 more tick -> RUN, edited hour retained, cntSec not advanced during set.
- Assert rst in SET_MIN after edits -> next edge shows all outputs at reset values; a tick in the same cycle as rst is ignored.
